toaplan2_pcm_arb: RTL and testbench

TOAPLAN2_PCM_ARB -- requirements
Module: toaplan2_pcm_arb

---
 rtl/toaplan2_pcm_arb.sv | 128 ++++++++++++
 tb/tb_toaplan2_pcm_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/toaplan2_pcm_arb.sv
// Two-requester ADPCM ROM arbiter with a one-byte cache per requester over a shared SDRAM slot.
// Miss-to-hit takes 3 cycles with a zero-wait ROM. A fetch that waits TMO cycles is abandoned and sets TIMEOUT.
module toaplan2_pcm_arb #(
  parameter logic [19:0] OFFSET1 = 20'h40000,
  parameter logic [7:0]  TMO     = 8'd255
) (
  input  logic        CLK96,
  input  logic        RESET96,
  input  logic        CS0,
  input  logic        CS1,
  input  logic [17:0] A0,
  input  logic [17:0] A1,
  input  logic [1:0]  BANK0,
  input  logic [1:0]  BANK1,
  output logic [7:0]  DATA0,
  output logic [7:0]  DATA1,
  output logic        OK0,
  output logic        OK1,
  output logic        PCM_CS,
  output logic [19:0] PCM_ADDR,
  input  logic [7:0]  PCM_DOUT,
  input  logic        PCM_OK,
  output logic        TIMEOUT
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t      state, state_nx;
  logic [19:0] fa0, fa1;
  logic [19:0] tag0, tag1;
  logic [7:0]  dat0, dat1;
  logic        vld0, vld1;
  logic        hit0, hit1, pend0, pend1;
  logic        last, gnt;
  logic [7:0]  wait_cnt;
  logic        grant_go, grant_sel, fill_go, abort_go;

  assign fa0 = {BANK0, A0};
  assign fa1 = {BANK1, A1} + OFFSET1;

  // Tag holds the full 20-bit address, so a bank switch simply misses.
  assign hit0  = vld0 && (tag0 == fa0);
  assign hit1  = vld1 && (tag1 == fa1);
  assign pend0 = CS0 && !hit0;
  assign pend1 = CS1 && !hit1;

  assign OK0   = hit0;
  assign OK1   = hit1;
  assign DATA0 = dat0;
  assign DATA1 = dat1;

  always_comb begin
    state_nx  = state;
    grant_go  = 1'b0;
    grant_sel = 1'b0;
    fill_go   = 1'b0;
    abort_go  = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          grant_go  = 1'b1;
          grant_sel = (pend0 && pend1) ? ~last : pend1;
          state_nx  = ISSUE;
        end
      end
      // PCM_OK may still reflect the previous address here, so it is ignored.
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (PCM_OK) begin
          fill_go  = 1'b1;
          state_nx = IDLE;
        end else if (wait_cnt == TMO - 8'd1) begin
          abort_go = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state    <= IDLE;
      PCM_CS   <= 1'b0;
      PCM_ADDR <= 20'd0;
      gnt      <= 1'b0;
      last     <= 1'b1;
      wait_cnt <= 8'd0;
      TIMEOUT  <= 1'b0;
      vld0     <= 1'b0;
      vld1     <= 1'b0;
      tag0     <= 20'd0;
      tag1     <= 20'd0;
      dat0     <= 8'd0;
      dat1     <= 8'd0;
    end else begin
      state <= state_nx;
      if (grant_go) begin
        PCM_CS   <= 1'b1;
        PCM_ADDR <= grant_sel ? fa1 : fa0;
        gnt      <= grant_sel;
        last     <= grant_sel;
      end
      if (state == ISSUE)
        wait_cnt <= 8'd0;
      else if (state == WAIT)
        wait_cnt <= wait_cnt + 8'd1;
      // The fill uses the latched address, even if the requester has moved on.
      if (fill_go) begin
        PCM_CS <= 1'b0;
        if (gnt) begin
          vld1 <= 1'b1;
          tag1 <= PCM_ADDR;
          dat1 <= PCM_DOUT;
        end else begin
          vld0 <= 1'b1;
          tag0 <= PCM_ADDR;
          dat0 <= PCM_DOUT;
        end
      end
      if (abort_go) begin
        PCM_CS  <= 1'b0;
        TIMEOUT <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_toaplan2_pcm_arb.sv
// Bench for toaplan2_pcm_arb: directed scenarios plus randomized traffic,
// every cycle compared against a transaction-level model of the cache and arbiter.
module tb_toaplan2_pcm_arb;

  localparam logic [19:0] OFF1 = 20'h40000;
  localparam int          TMO_CYC = 255;

  logic        CLK96, RESET96, CS0, CS1, PCM_OK, PCM_CS, OK0, OK1, TIMEOUT;
  logic [17:0] A0, A1;
  logic [1:0]  BANK0, BANK1;
  logic [7:0]  DATA0, DATA1, PCM_DOUT;
  logic [19:0] PCM_ADDR;

  toaplan2_pcm_arb #(.OFFSET1(OFF1), .TMO(8'd255)) dut (
    .CLK96(CLK96), .RESET96(RESET96), .CS0(CS0), .CS1(CS1), .A0(A0), .A1(A1),
    .BANK0(BANK0), .BANK1(BANK1), .DATA0(DATA0), .DATA1(DATA1), .OK0(OK0), .OK1(OK1),
    .PCM_CS(PCM_CS), .PCM_ADDR(PCM_ADDR), .PCM_DOUT(PCM_DOUT), .PCM_OK(PCM_OK),
    .TIMEOUT(TIMEOUT)
  );

  initial CLK96 = 1'b0;
  always #5 CLK96 = ~CLK96;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: cache entries plus the one outstanding fetch, if any.
  bit          mv[2];
  logic [19:0] mt[2];
  logic [7:0]  md[2];
  bit          mlast, mbusy, mwho, mto;
  logic [19:0] maddr;
  int          mage;  // 0 = settle cycle, k >= 1 = k-th cycle waiting on the ROM

  function automatic logic [19:0] full_addr(input bit who);
    logic [19:0] f;
    if (who) f = {BANK1, A1} + OFF1;
    else     f = {BANK0, A0};
    return f;
  endfunction

  task automatic cycle();
    bit h0, h1, p0, p1, w;
    @(negedge CLK96);
    h0 = mv[0] && (mt[0] == full_addr(1'b0));
    h1 = mv[1] && (mt[1] == full_addr(1'b1));
    if (chk_en) begin
      chk("ok0",      32'(OK0),      32'(h0));
      chk("ok1",      32'(OK1),      32'(h1));
      chk("data0",    32'(DATA0),    32'(md[0]));
      chk("data1",    32'(DATA1),    32'(md[1]));
      chk("pcm_cs",   32'(PCM_CS),   32'(mbusy));
      chk("pcm_addr", 32'(PCM_ADDR), 32'(maddr));
      chk("timeout",  32'(TIMEOUT),  32'(mto));
    end
    @(posedge CLK96);
    if (RESET96) begin
      mv[0] = 0; mv[1] = 0; mt[0] = '0; mt[1] = '0; md[0] = '0; md[1] = '0;
      mlast = 1; mbusy = 0; mwho = 0; mto = 0; maddr = '0; mage = 0;
    end else if (mbusy) begin
      if (mage == 0) mage = 1;
      else if (PCM_OK) begin
        mv[mwho] = 1; mt[mwho] = maddr; md[mwho] = PCM_DOUT; mbusy = 0;
      end else if (mage == TMO_CYC) begin
        mbusy = 0; mto = 1;
      end else mage++;
    end else begin
      p0 = CS0 && !h0;
      p1 = CS1 && !h1;
      if (p0 || p1) begin
        w = (p0 && p1) ? !mlast : p1;
        mwho = w; mlast = w; maddr = full_addr(w); mbusy = 1; mage = 0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    RESET96 = 1'b1;
    cycle();
    chk_en = 1'b1;
    cycle();
    RESET96 = 1'b0;
  endtask

  function automatic logic [17:0] pick_a();
    case ($urandom_range(3))
      0:       return 18'h00010;
      1:       return 18'h00011;
      2:       return 18'h00020;
      default: return 18'h3FFFF;
    endcase
  endfunction

  int ok0_at, ok1_at, hi_cnt;
  bit seen_a1;

  initial begin
    RESET96 = 1; CS0 = 0; CS1 = 0; A0 = '0; A1 = '0; BANK0 = '0; BANK1 = '0;
    PCM_OK = 0; PCM_DOUT = '0;
    mlast = 1;

    // Reset state
    do_reset();
    chk("rst_pcm_cs",   32'(PCM_CS),   32'd0);
    chk("rst_pcm_addr", 32'(PCM_ADDR), 32'd0);
    chk("rst_ok0",      32'(OK0),      32'd0);
    chk("rst_data1",    32'(DATA1),    32'd0);
    chk("rst_timeout",  32'(TIMEOUT),  32'd0);

    // Single miss, zero-wait ROM: hit on cycle 3, then no further fetch
    CS0 = 1; A0 = 18'h00010; BANK0 = 0; PCM_OK = 1; PCM_DOUT = 8'h5A;
    cycle();
    chk("s1_cs",   32'(PCM_CS),   32'd1);
    chk("s1_addr", 32'(PCM_ADDR), 32'h00010);
    cycle();
    cycle();
    chk("s1_ok0",   32'(OK0),   32'd1);
    chk("s1_data0", 32'(DATA0), 32'h5A);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("s1_no_refetch", 32'(PCM_CS), 32'd0);
    end

    // Simultaneous misses: requester 0 first, then requester 1 at the offset address
    CS0 = 0; do_reset();
    CS0 = 1; CS1 = 1; A0 = 18'h00010; A1 = 18'h00020; BANK1 = 0; PCM_OK = 1; PCM_DOUT = 8'hC3;
    cycle();
    chk("s2_first_addr", 32'(PCM_ADDR), 32'h00010);
    ok0_at = -1; ok1_at = -1; seen_a1 = 0;
    for (int i = 2; i < 20; i++) begin
      cycle();
      if (PCM_CS && PCM_ADDR == 20'h40020) seen_a1 = 1;
      if (OK0 && ok0_at < 0) ok0_at = i;
      if (OK1 && ok1_at < 0) ok1_at = i;
    end
    chk("s2_second_addr_seen", 32'(seen_a1), 32'd1);
    chk("s2_ok0_cycle", 32'(ok0_at), 32'd3);
    chk("s2_ok1_after_ok0", 32'(ok1_at > ok0_at), 32'd1);

    // Offset addition wraps modulo 2^20
    CS0 = 0; CS1 = 0; do_reset();
    CS1 = 1; BANK1 = 2'b11; A1 = 18'h3FFFF;
    cycle();
    chk("s3_wrap_addr", 32'(PCM_ADDR), 32'h3FFFF);
    cycle(); cycle(); cycle();
    chk("s3_ok1", 32'(OK1), 32'd1);

    // Address change while waiting: stale fill completes, then a fresh fetch
    CS1 = 0; BANK1 = 0; do_reset();
    CS0 = 1; A0 = 18'h00010; PCM_OK = 0;
    cycle(); cycle();
    A0 = 18'h00011;
    for (int i = 0; i < 4; i++) cycle();
    PCM_OK = 1;
    cycle();
    chk("s4_stale_ok0", 32'(OK0), 32'd0);
    cycle();
    chk("s4_refetch_addr", 32'(PCM_ADDR), 32'h00011);
    cycle(); cycle();
    chk("s4_final_ok0", 32'(OK0), 32'd1);

    // ROM never answers: abort after TMO waiting cycles, sticky TIMEOUT, retry
    CS0 = 0; do_reset();
    CS0 = 1; A0 = 18'h00010; PCM_OK = 0;
    hi_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      cycle();
      if (PCM_CS) hi_cnt++;
      else if (hi_cnt > 0) break;
    end
    chk("s5_cs_high_cycles", 32'(hi_cnt), 32'd256);
    chk("s5_timeout", 32'(TIMEOUT), 32'd1);
    chk("s5_ok0", 32'(OK0), 32'd0);
    cycle();
    chk("s5_retry", 32'(PCM_CS), 32'd1);
    PCM_OK = 1;
    cycle(); cycle(); cycle();
    chk("s5_ok0_after", 32'(OK0), 32'd1);
    chk("s5_timeout_sticky", 32'(TIMEOUT), 32'd1);

    // Reset during a fetch: a late ROM answer must not fill
    CS0 = 0; do_reset();
    CS0 = 1; A0 = 18'h00010; PCM_OK = 0;
    cycle(); cycle();
    RESET96 = 1;
    cycle();
    RESET96 = 0; CS0 = 0; PCM_OK = 1;
    cycle();
    chk("s6_ok0", 32'(OK0), 32'd0);
    chk("s6_cs", 32'(PCM_CS), 32'd0);
    CS0 = 1;
    cycle();
    chk("s6_refetch", 32'(PCM_CS), 32'd1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      CS0 = ($urandom_range(3) != 0);
      CS1 = ($urandom_range(3) != 0);
      if ($urandom_range(7) == 0) A0 = pick_a();
      if ($urandom_range(7) == 0) A1 = pick_a();
      if ($urandom_range(15) == 0) BANK0 = 2'($urandom_range(3));
      if ($urandom_range(15) == 0) BANK1 = 2'($urandom_range(3));
      PCM_OK   = ($urandom_range(2) != 0);
      PCM_DOUT = 8'($urandom);
      RESET96  = ($urandom_range(299) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
